// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Purpose  : Shared opcode, funct3, ALU-op and FSM-state definitions for the
//            multicycle RV32I core.
// Revision : 1.0
// ============================================================================
package rv32i_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F
  } opcode_e;

  localparam logic [2:0] c_F3_BEQ  = 3'b000;
  localparam logic [2:0] c_F3_BNE  = 3'b001;
  localparam logic [2:0] c_F3_BLT  = 3'b100;
  localparam logic [2:0] c_F3_BGE  = 3'b101;
  localparam logic [2:0] c_F3_BLTU = 3'b110;
  localparam logic [2:0] c_F3_BGEU = 3'b111;

  localparam logic [2:0] c_F3_LB   = 3'b000;
  localparam logic [2:0] c_F3_LH   = 3'b001;
  localparam logic [2:0] c_F3_LW   = 3'b010;
  localparam logic [2:0] c_F3_LBU  = 3'b100;
  localparam logic [2:0] c_F3_LHU  = 3'b101;

  localparam logic [2:0] c_F3_SW   = 3'b010;

  localparam logic [2:0] c_F3_ADD  = 3'b000;
  localparam logic [2:0] c_F3_SLL  = 3'b001;
  localparam logic [2:0] c_F3_SLT  = 3'b010;
  localparam logic [2:0] c_F3_SLTU = 3'b011;
  localparam logic [2:0] c_F3_XOR  = 3'b100;
  localparam logic [2:0] c_F3_SR   = 3'b101;
  localparam logic [2:0] c_F3_OR   = 3'b110;
  localparam logic [2:0] c_F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM_ADR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_UPPER, S_ERROR
  } state_e;

  // funct7[5] selects sub/sra; sub exists only for register-register ops
  function automatic alu_op_e alu_op_decode(input logic [2:0] f3,
                                            input logic       alt,
                                            input logic       is_reg);
    alu_op_e op;
    case (f3)
      c_F3_ADD:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      c_F3_SLL:  op = ALU_SLL;
      c_F3_SLT:  op = ALU_SLT;
      c_F3_SLTU: op = ALU_SLTU;
      c_F3_XOR:  op = ALU_XOR;
      c_F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      c_F3_OR:   op = ALU_OR;
      default:   op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_alu.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_alu
// Purpose  : Combinational RV32I ALU with compare flags, shared by EXEC/BRANCH.
// Revision : 1.0
// ============================================================================
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_op,
  output logic [31:0] o_result,
  output logic        o_eq,
  output logic        o_lt,
  output logic        o_ltu
);

  assign o_eq  = (i_a == i_b);
  assign o_lt  = ($signed(i_a) < $signed(i_b));
  assign o_ltu = (i_a < i_b);

  always_comb begin
    o_result = 32'h0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLL:  o_result = i_a << i_b[4:0];
      ALU_SLT:  o_result = {31'h0, o_lt};
      ALU_SLTU: o_result = {31'h0, o_ltu};
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> i_b[4:0];
      ALU_SRA:  o_result = $signed(i_a) >>> i_b[4:0];
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      default:  o_result = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32i_multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_multicycle_cpu
// Purpose  : Unpipelined multicycle RV32I core on a single shared memory port.
// Revision : 1.0
// ============================================================================
module rv32i_multicycle_cpu
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_ena,
  output logic [31:0] mem_wr_data,
  output logic [31:0] PC
);

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_pc, r_pc_old, r_ir, r_a, r_b, r_imm;
  logic [31:0] r_alu_out, r_addr, r_data;
  logic [31:0] r_rf [32];

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_rs1_val, w_rs2_val, w_imm;
  logic [31:0] w_alu_b, w_alu_res, w_pc_imm, w_pc_old_4;
  alu_op_e     w_alu_op;
  logic        w_eq, w_lt, w_ltu, w_taken;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_val;
  logic        w_rf_we;
  logic [31:0] w_rf_wdata;

  assign w_opcode  = r_ir[6:0];
  assign w_f3      = r_ir[14:12];
  assign w_rd      = r_ir[11:7];
  assign w_rs1     = r_ir[19:15];
  assign w_rs2     = r_ir[24:20];
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'h0 : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'h0 : r_rf[w_rs2];

  assign w_pc_imm   = r_pc_old + r_imm;
  assign w_pc_old_4 = r_pc_old + 32'd4;

  always_comb begin
    case (w_opcode)
      OPC_STORE:          w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      OPC_BRANCH:         w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: w_imm = {r_ir[31:12], 12'h0};
      OPC_JAL:            w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      default:            w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    endcase
  end

  // Outside EXEC the ALU is an adder for A+IMM (load/store address, jalr target)
  assign w_alu_op = (r_state == S_EXEC)
                  ? alu_op_decode(w_f3, r_ir[30], w_opcode == OPC_OP)
                  : ALU_ADD;
  assign w_alu_b  = ((r_state == S_BRANCH) || ((r_state == S_EXEC) && (w_opcode == OPC_OP)))
                  ? r_b : r_imm;

  rv32i_alu u_alu (
    .i_a      (r_a),
    .i_b      (w_alu_b),
    .i_op     (w_alu_op),
    .o_result (w_alu_res),
    .o_eq     (w_eq),
    .o_lt     (w_lt),
    .o_ltu    (w_ltu)
  );

  always_comb begin
    case (w_f3)
      c_F3_BEQ:  w_taken = w_eq;
      c_F3_BNE:  w_taken = !w_eq;
      c_F3_BLT:  w_taken = w_lt;
      c_F3_BGE:  w_taken = !w_lt;
      c_F3_BLTU: w_taken = w_ltu;
      c_F3_BGEU: w_taken = !w_ltu;
      default:   w_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_ld_byte = r_data[7:0];
      2'd1:    w_ld_byte = r_data[15:8];
      2'd2:    w_ld_byte = r_data[23:16];
      default: w_ld_byte = r_data[31:24];
    endcase
    w_ld_half = r_addr[1] ? r_data[31:16] : r_data[15:0];
    case (w_f3)
      c_F3_LB:  w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
      c_F3_LH:  w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
      c_F3_LBU: w_ld_val = {24'h0, w_ld_byte};
      c_F3_LHU: w_ld_val = {16'h0, w_ld_half};
      default:  w_ld_val = r_data;
    endcase
  end

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_wdata = 32'h0;
    case (r_state)
      S_ALU_WB: begin w_rf_we = 1'b1; w_rf_wdata = r_alu_out; end
      S_MEM_WB: begin w_rf_we = 1'b1; w_rf_wdata = w_ld_val; end
      S_JUMP:   begin w_rf_we = 1'b1; w_rf_wdata = w_pc_old_4; end
      S_UPPER:  begin
        w_rf_we    = 1'b1;
        w_rf_wdata = (w_opcode == OPC_LUI) ? r_imm : w_pc_imm;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else if (ena) r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    mem_addr     = {r_pc[31:2], 2'b00};
    mem_wr_ena   = 1'b0;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OPC_OP, OPC_OP_IMM: w_next_state = S_EXEC;
          OPC_LOAD:   w_next_state = (w_f3 inside {c_F3_LB, c_F3_LH, c_F3_LW, c_F3_LBU, c_F3_LHU})
                                     ? S_MEM_ADR : S_ERROR;
          OPC_STORE:  w_next_state = (w_f3 == c_F3_SW) ? S_MEM_ADR : S_ERROR;
          OPC_BRANCH: w_next_state = (w_f3[2:1] != 2'b01) ? S_BRANCH : S_ERROR;
          OPC_JAL:    w_next_state = S_JUMP;
          OPC_JALR:   w_next_state = (w_f3 == 3'b000) ? S_JUMP : S_ERROR;
          OPC_LUI, OPC_AUIPC: w_next_state = S_UPPER;
          default:    w_next_state = S_ERROR;
        endcase
      end
      S_EXEC:    w_next_state = S_ALU_WB;
      S_MEM_ADR: w_next_state = (w_opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        mem_addr     = {r_addr[31:2], 2'b00};
        w_next_state = S_MEM_WB;
      end
      S_MEM_WR: begin
        mem_addr     = {r_addr[31:2], 2'b00};
        mem_wr_ena   = ena;
        w_next_state = S_FETCH;
      end
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_UPPER: w_next_state = S_FETCH;
      default:   w_next_state = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_pc_old  <= 32'h0;
      r_ir      <= 32'h0;
      r_a       <= 32'h0;
      r_b       <= 32'h0;
      r_imm     <= 32'h0;
      r_alu_out <= 32'h0;
      r_addr    <= 32'h0;
      r_data    <= 32'h0;
    end else if (ena) begin
      case (r_state)
        S_FETCH: begin
          r_ir     <= mem_rd_data;
          r_pc_old <= r_pc;
          r_pc     <= r_pc + 32'd4;
        end
        S_DECODE: begin
          r_a   <= w_rs1_val;
          r_b   <= w_rs2_val;
          r_imm <= w_imm;
        end
        S_EXEC:    r_alu_out <= w_alu_res;
        S_MEM_ADR: r_addr    <= w_alu_res;
        S_MEM_RD:  r_data    <= mem_rd_data;
        S_BRANCH:  if (w_taken) r_pc <= w_pc_imm;
        S_JUMP:    r_pc <= (w_opcode == OPC_JAL) ? w_pc_imm : {w_alu_res[31:1], 1'b0};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'h0;
    end else if (ena && w_rf_we && (w_rd != 5'd0)) begin
      r_rf[w_rd] <= w_rf_wdata;
    end
  end

  assign mem_wr_data = r_b;
  assign PC          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_multicycle_cpu
// Purpose  : Self-checking bench: ALU vector table plus hand-written sequences.
// Revision : 1.0
// ============================================================================
module tb_rv32i_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [31:0] mem_addr, mem_rd_data, mem_wr_data, PC;
  logic        mem_wr_ena;

  logic [31:0] mem [256];
  logic        tb_clr = 1'b0;
  logic        tb_ld_en = 1'b0;
  logic [7:0]  tb_ld_addr = 8'h0;
  logic [31:0] tb_ld_data = 32'h0;

  typedef struct { string tag; logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    string name; logic is_imm; logic [6:0] f7; logic [2:0] f3; logic [11:0] imm;
    logic [31:0] a; logic [31:0] b; logic [31:0] exp;
  } vec_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] prog[$];
  vec_t        vecs[14];
  int          checks = 0;
  int          errors = 0;

  rv32i_multicycle_cpu #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .ena(ena), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_ena(mem_wr_ena), .mem_wr_data(mem_wr_data), .PC(PC)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (tb_clr) for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    else if (tb_ld_en) mem[tb_ld_addr] <= tb_ld_data;
    else if (mem_wr_ena && !rst) mem[mem_addr[9:2]] <= mem_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every observed write strobe must match the next expected store
  always @(negedge clk) begin
    if (mem_wr_ena && !rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.tag, "_addr"}, mem_addr, mon_e.addr);
        chk({mon_e.tag, "_data"}, mem_wr_data, mon_e.data);
      end
    end
  end

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  function automatic vec_t mk(string n, logic im, logic [6:0] f7, logic [2:0] f3,
                              logic [11:0] imm, logic [31:0] a, logic [31:0] b, logic [31:0] e);
    vec_t v;
    v.name = n; v.is_imm = im; v.f7 = f7; v.f3 = f3; v.imm = imm;
    v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic poke(input int byte_addr, input logic [31:0] d);
    tb_ld_en = 1'b1; tb_ld_addr = byte_addr[9:2]; tb_ld_data = d;
    step(1);
    tb_ld_en = 1'b0;
  endtask

  task automatic expect_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.tag = tag; w.addr = a; w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic begin_prog();
    rst = 1'b1; ena = 1'b1;
    tb_clr = 1'b1; step(1); tb_clr = 1'b0;
    exp_q.delete(); prog.delete();
  endtask

  task automatic load_and_start();
    foreach (prog[i]) poke(i * 4, prog[i]);
    chk("reset_pc", PC, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_wr_ena", {31'h0, mem_wr_ena}, 32'h0);
    rst = 1'b0;
  endtask

  task automatic finish_prog(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_final_pc"}, PC, exp_pc);
    chk({tag, "_pending_writes"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    vecs[0]  = mk("add",   1'b0, 7'h00, 3'd0, 12'h000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000);
    vecs[1]  = mk("sub",   1'b0, 7'h20, 3'd0, 12'h000, 32'h5,         32'h7,         32'hFFFF_FFFE);
    vecs[2]  = mk("sll",   1'b0, 7'h00, 3'd1, 12'h000, 32'h1,         32'h21,        32'h2);
    vecs[3]  = mk("slt",   1'b0, 7'h00, 3'd2, 12'h000, 32'hFFFF_FFFF, 32'h1,         32'h1);
    vecs[4]  = mk("sltu",  1'b0, 7'h00, 3'd3, 12'h000, 32'hFFFF_FFFF, 32'h1,         32'h0);
    vecs[5]  = mk("xor",   1'b0, 7'h00, 3'd4, 12'h000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    vecs[6]  = mk("srl",   1'b0, 7'h00, 3'd5, 12'h000, 32'h8000_0000, 32'h4,         32'h0800_0000);
    vecs[7]  = mk("sra",   1'b0, 7'h20, 3'd5, 12'h000, 32'h8000_0000, 32'h4,         32'hF800_0000);
    vecs[8]  = mk("or",    1'b0, 7'h00, 3'd6, 12'h000, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    vecs[9]  = mk("and",   1'b0, 7'h00, 3'd7, 12'h000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
    vecs[10] = mk("addi",  1'b1, 7'h00, 3'd0, 12'hFF9, 32'h5,         32'h0,         32'hFFFF_FFFE);
    vecs[11] = mk("srai",  1'b1, 7'h00, 3'd5, 12'h41F, 32'h8000_0000, 32'h0,         32'hFFFF_FFFF);
    vecs[12] = mk("sltiu", 1'b1, 7'h00, 3'd3, 12'hFFF, 32'h0,         32'h0,         32'h1);
    vecs[13] = mk("xori",  1'b1, 7'h00, 3'd4, 12'hFFF, 32'h0000_FFFF, 32'h0,         32'hFFFF_0000);

    // addi chain, 4 cycles per ALU instruction
    begin_prog();
    prog.push_back(enc_i(5, 0, 0, 1, 7'h13));
    prog.push_back(enc_i(-7, 1, 0, 2, 7'h13));
    prog.push_back(enc_s(12'h080, 1, 0, 2));
    prog.push_back(enc_s(12'h084, 2, 0, 2));
    prog.push_back(32'h0);
    expect_wr("addi_x1", 32'h80, 32'h5);
    expect_wr("addi_x2", 32'h84, 32'hFFFF_FFFE);
    load_and_start();
    step(8);
    chk("addi_pc_after_8", PC, 32'h8);
    step(20);
    finish_prog("addi", 32'h14);

    // lui/sw/lw round trip and sub-word loads
    begin_prog();
    prog.push_back(enc_u(20'h12345, 3, 7'h37));
    prog.push_back(enc_s(12'h040, 3, 0, 2));
    prog.push_back(enc_i(12'h040, 0, 2, 4, 7'h03));
    prog.push_back(enc_s(12'h044, 4, 0, 2));
    prog.push_back(enc_i(12'h049, 0, 0, 5, 7'h03));
    prog.push_back(enc_i(12'h049, 0, 4, 6, 7'h03));
    prog.push_back(enc_i(12'h048, 0, 1, 7, 7'h03));
    prog.push_back(enc_i(12'h04A, 0, 5, 8, 7'h03));
    prog.push_back(enc_s(12'h04C, 5, 0, 2));
    prog.push_back(enc_s(12'h050, 6, 0, 2));
    prog.push_back(enc_s(12'h054, 7, 0, 2));
    prog.push_back(enc_s(12'h058, 8, 0, 2));
    prog.push_back(32'h0);
    poke(32'h48, 32'hC001_8000);
    expect_wr("sw_lui", 32'h40, 32'h1234_5000);
    expect_wr("lw",     32'h44, 32'h1234_5000);
    expect_wr("lb",     32'h4C, 32'hFFFF_FF80);
    expect_wr("lbu",    32'h50, 32'h0000_0080);
    expect_wr("lh",     32'h54, 32'hFFFF_8000);
    expect_wr("lhu",    32'h58, 32'h0000_C001);
    load_and_start();
    step(70);
    finish_prog("mem", 32'h34);

    // branches, jal, jalr, auipc with 3-cycle timing checkpoints
    begin_prog();
    prog.push_back(enc_i(1, 0, 0, 1, 7'h13));
    prog.push_back(enc_i(1, 0, 0, 2, 7'h13));
    prog.push_back(enc_i(0, 0, 0, 0, 7'h13));
    prog.push_back(enc_i(0, 0, 0, 0, 7'h13));
    prog.push_back(enc_b(12, 2, 1, 0));
    prog.push_back(32'h0);
    prog.push_back(enc_i(1, 1, 0, 0, 7'h67));
    prog.push_back(enc_b(8, 2, 1, 1));
    prog.push_back(enc_j(-8, 1));
    prog.push_back(enc_s(12'h094, 1, 0, 2));
    prog.push_back(enc_u(1, 5, 7'h17));
    prog.push_back(enc_s(12'h098, 5, 0, 2));
    prog.push_back(32'h0);
    expect_wr("jal_link", 32'h94, 32'h24);
    expect_wr("auipc",    32'h98, 32'h1028);
    load_and_start();
    step(16); chk("pc_at_beq", PC, 32'h10);
    step(3);  chk("beq_taken", PC, 32'h1C);
    step(3);  chk("bne_not_taken", PC, 32'h20);
    step(3);  chk("jal_target", PC, 32'h18);
    step(3);  chk("jalr_target", PC, 32'h24);
    step(20);
    finish_prog("branch", 32'h34);

    // clock-enable hold with a store pending, then an illegal sb
    begin_prog();
    prog.push_back(enc_i(12'h055, 0, 0, 1, 7'h13));
    prog.push_back(enc_s(12'h0A0, 1, 0, 2));
    prog.push_back(enc_s(12'h0A4, 1, 0, 0));
    expect_wr("sw_after_hold", 32'hA0, 32'h55);
    load_and_start();
    step(7);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_wr_ena", {31'h0, mem_wr_ena}, 32'h0);
      chk("hold_pc", PC, 32'h8);
      chk("hold_mem_addr", mem_addr, 32'hA0);
    end
    ena = 1'b1;
    step(1);
    chk("hold_write_done", exp_q.size(), 32'h0);
    step(12);
    finish_prog("sb_error", 32'h0C);

    // ALU vector table: operands loaded from memory, result stored back
    foreach (vecs[k]) begin
      begin_prog();
      prog.push_back(enc_i(12'h100, 0, 2, 1, 7'h03));
      prog.push_back(enc_i(12'h104, 0, 2, 2, 7'h03));
      if (vecs[k].is_imm) prog.push_back(enc_i(int'(vecs[k].imm), 1, int'(vecs[k].f3), 3, 7'h13));
      else prog.push_back(enc_r(int'(vecs[k].f7), 2, 1, int'(vecs[k].f3), 3, 7'h33));
      prog.push_back(enc_s(12'h108, 3, 0, 2));
      prog.push_back(32'h0);
      poke(32'h100, vecs[k].a);
      poke(32'h104, vecs[k].b);
      expect_wr(vecs[k].name, 32'h108, vecs[k].exp);
      load_and_start();
      step(30);
      finish_prog(vecs[k].name, 32'h14);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
